// File: rtl/rr_grant_arbiter_pkg.sv
// rtl/rr_grant_arbiter_pkg.sv - shared constants for the round-robin grant arbiter
package rr_grant_arbiter_pkg;

    localparam int NUM_REQ = 4;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GRANT = 2'b01;
    localparam logic [1:0] ST_GAP   = 2'b10;

endpackage

// File: rtl/rr_grant_arbiter_grant_decoder.sv
// rtl/rr_grant_arbiter_grant_decoder.sv - 2-to-4 enable decoder producing the one-hot grant
module grant_decoder
    import rr_grant_arbiter_pkg::*;
(
    input  logic [1:0]         grant_addr,
    input  logic               grant_valid,
    output logic [NUM_REQ-1:0] grant
);

    // Decode the owner index into a single set bit, or nothing when no owner exists.
    always_comb begin
        grant = '0;
        if (grant_valid) begin
            grant = NUM_REQ'(1) << grant_addr;
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - 4-way round-robin arbiter with hold limit and turnaround gap
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         grant_addr,
    output logic               grant_valid,
    output logic               preempt
);

    localparam logic [CNT_W-1:0] HOLD_CAP = CNT_W'(MAX_HOLD - 1);

    logic [1:0]         state;
    logic [1:0]         ptr;
    logic [1:0]         owner;
    logic [CNT_W-1:0]   hold_cnt;
    logic               preempt_q;

    logic [NUM_REQ-1:0] rot_req;
    logic [1:0]         rot_idx;
    logic               pick_found;
    logic [1:0]         pick_idx;
    logic               others_wait;
    logic [NUM_REQ-1:0] owner_mask;

    // Rotate requests so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
    always_comb begin
        rot_req = '0;
        rot_idx = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            logic [1:0] src;
            src        = ptr + 2'(i);
            rot_req[i] = req[src];
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                rot_idx = 2'(i);
            end
        end
        pick_found = |rot_req;
        pick_idx   = rot_idx + ptr;
    end

    // Anyone other than the current owner asking for the resource.
    always_comb begin
        owner_mask  = NUM_REQ'(1) << owner;
        others_wait = |(req & ~owner_mask);
    end

    // Ownership state machine; ptr moves past the owner only when ownership ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= 2'd0;
            owner     <= 2'd0;
            hold_cnt  <= '0;
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state)
                ST_IDLE, ST_GAP: begin
                    if (pick_found) begin
                        state    <= ST_GRANT;
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                    end else begin
                        state    <= ST_IDLE;
                        owner    <= 2'd0;
                    end
                end
                ST_GRANT: begin
                    if (!req[owner]) begin
                        // A voluntary release wins over a simultaneous hold-limit hit.
                        state <= ST_GAP;
                        ptr   <= owner + 2'd1;
                        owner <= 2'd0;
                    end else if ((hold_cnt == HOLD_CAP) && others_wait) begin
                        state     <= ST_GAP;
                        ptr       <= owner + 2'd1;
                        owner     <= 2'd0;
                        preempt_q <= 1'b1;
                    end else if (hold_cnt != HOLD_CAP) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    owner <= 2'd0;
                end
            endcase
        end
    end

    assign grant_valid = (state == ST_GRANT);
    assign grant_addr  = owner;
    assign preempt     = preempt_q;

    grant_decoder u_grant_decoder (
        .grant_addr  (grant_addr),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - randomized self-checking bench for rr_grant_arbiter
module tb_rr_grant_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_addr;
    logic       grant_valid;
    logic       preempt;

    int n_checks;
    int n_pass;

    // reference model: 0 = nobody owns, 1 = owned, 2 = turnaround
    int m_mode;
    int m_owner;
    int m_ptr;
    int m_held;
    int m_pre;

    rr_grant_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_addr  (grant_addr),
        .grant_valid (grant_valid),
        .preempt     (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int p, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_held  = 0;
        m_pre   = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int w;
        int others;
        m_pre = 0;
        if (m_mode == 1) begin
            others = 0;
            for (int k = 0; k < 4; k++) if (k != m_owner && r[k]) others = 1;
            if (!r[m_owner]) begin
                m_mode = 2;
                m_ptr  = (m_owner + 1) % 4;
            end else if (m_held >= MAX_HOLD && others != 0) begin
                m_mode = 2;
                m_ptr  = (m_owner + 1) % 4;
                m_pre  = 1;
            end else begin
                m_held = m_held + 1;
            end
        end else begin
            w = pick(m_ptr, r);
            if (w >= 0) begin
                m_mode  = 1;
                m_owner = w;
                m_held  = 1;
            end else begin
                m_mode = 0;
            end
        end
    endtask

    // Called at a falling edge: compare outputs, then present the next request vector.
    task automatic cycle(input logic [3:0] nreq);
        logic [3:0] eg;
        eg = (m_mode == 1) ? 4'(1 << m_owner) : 4'b0000;
        check("grant", 32'(grant), 32'(eg));
        check("grant_addr", 32'(grant_addr), (m_mode == 1) ? 32'(m_owner) : 32'd0);
        check("grant_valid", 32'(grant_valid), (m_mode == 1) ? 32'd1 : 32'd0);
        check("preempt", 32'(preempt), 32'(m_pre));
        check("onehot0", 32'($onehot0(grant)), 32'd1);
        req = nreq;
        model_step(nreq);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int pre_cnt;
        int same;
        int order[$];
        int exp_order[5];
        logic [3:0] r;

        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        req      = 4'b1111;
        model_reset();

        // reset held with all requests pending, then the first grant
        @(negedge clk);
        @(negedge clk);
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_valid", 32'(grant_valid), 32'd0);
        reset = 1'b0;
        model_reset();
        cycle(4'b1111);
        check("first_grant", 32'(grant), 32'h1);
        check("first_addr", 32'(grant_addr), 32'd0);

        // full contention: 8 cycles each, one preempt per owner, order 0,1,2,3,0
        pre_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (preempt) pre_cnt++;
            if (grant_valid && (order.size() == 0 || order[$] != int'(grant_addr)))
                order.push_back(int'(grant_addr));
            cycle(4'b1111);
        end
        check("preempt_pulses", 32'(pre_cnt), 32'd4);
        check("order_len", 32'(order.size()), 32'd5);
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5 && i < order.size(); i++)
            check("order", 32'(order[i]), 32'(exp_order[i]));

        // owner 0 releases after 3 cycles, one gap, then requester 2
        do_reset();
        cycle(4'b0101);
        cycle(4'b0101);
        cycle(4'b0101);
        cycle(4'b0100);
        check("release_gap", 32'(grant), 32'd0);
        cycle(4'b0100);
        check("after_gap", 32'(grant), 32'h4);
        cycle(4'b0000);
        cycle(4'b0000);

        // lone requester keeps the grant with no preempt and no gap
        do_reset();
        cycle(4'b0010);
        same    = 0;
        pre_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (grant == 4'b0010) same++;
            if (preempt) pre_cnt++;
            cycle(4'b0010);
        end
        check("lone_hold", 32'(same), 32'd20);
        check("lone_preempt", 32'(pre_cnt), 32'd0);

        // owner 3 releases, pointer wraps to 0
        do_reset();
        cycle(4'b1000);
        cycle(4'b1001);
        cycle(4'b0011);
        check("wrap_gap", 32'(grant), 32'd0);
        cycle(4'b0011);
        check("wrap_grant", 32'(grant), 32'h1);
        cycle(4'b0000);

        // asynchronous reset in the middle of a grant
        do_reset();
        cycle(4'b0100);
        cycle(4'b0100);
        cycle(4'b0100);
        #2;
        reset = 1'b1;
        #1;
        check("async_grant", 32'(grant), 32'd0);
        check("async_valid", 32'(grant_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b0000;
        model_reset();

        // randomized requests with sticky bits so grants last long enough to hit the limit
        r = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            cycle(r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
